// File: rtl/display_pkg.sv
// Shared types and constants for the result display: FSM states, active-low
// seven-segment patterns and per-slot anode codes.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Nibble value that the decoder renders as an unlit digit.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam logic [2:0] LAST_ITER = 3'd4;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
        logic [3:0] an_code;
        case (slot)
            2'd0:    an_code = AN_SLOT0;
            2'd1:    an_code = AN_SLOT1;
            2'd2:    an_code = AN_SLOT2;
            default: an_code = AN_SLOT3;
        endcase
        return an_code;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern; any code
// above 9 renders as a blank digit.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Sign/magnitude result to multiplexed 4-digit common-anode display: a
// sequential double-dabble converter feeds digit registers that a scanner reads.
module result_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sign,
    input  logic [4:0] mag,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int         PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_load;
    logic         w_step;
    logic         w_commit;
    logic         w_change;

    logic         r_hold_sign;
    logic [4:0]   r_hold_mag;
    // {tens[3:0], units[3:0], remaining magnitude bits[4:0]}
    logic [12:0]  r_shift;
    logic [12:0]  w_shift_adj;
    logic [12:0]  w_shift_nxt;
    logic [2:0]   r_iter;

    logic [3:0]   r_units;
    logic [3:0]   r_tens;
    logic         r_neg;

    logic [PW-1:0] r_presc;
    logic          w_wrap;
    logic [1:0]    r_slot;
    logic [1:0]    w_slot_nxt;
    logic [3:0]    w_dec_in;
    logic [6:0]    w_dec_seg;
    logic [6:0]    w_seg_sel;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    assign w_change = ({sign, mag} != {r_hold_sign, r_hold_mag});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_change) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_iter == LAST_ITER) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);

    // Tens never exceeds 3, so the bit shifted out of the top nibble is always 0.
    assign w_shift_adj = {dd_adjust(r_shift[12:9]), dd_adjust(r_shift[8:5]), r_shift[4:0]};
    assign w_shift_nxt = {w_shift_adj[11:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_sign <= 1'b0;
            r_hold_mag  <= 5'd0;
            r_shift     <= 13'd0;
            r_iter      <= 3'd0;
        end else if (w_load) begin
            r_hold_sign <= sign;
            r_hold_mag  <= mag;
            r_shift     <= {8'd0, mag};
            r_iter      <= 3'd0;
        end else if (w_step) begin
            r_shift     <= w_shift_nxt;
            r_iter      <= r_iter + 3'd1;
        end
    end

    // Digit registers change only in DONE, so an aborted conversion leaves them intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_neg   <= 1'b0;
        end else if (w_commit) begin
            r_units <= r_shift[8:5];
            r_tens  <= r_shift[12:9];
            r_neg   <= r_hold_sign;
        end
    end

    assign w_wrap     = (r_presc == PRESC_MAX);
    assign w_slot_nxt = r_slot + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= 2'd3;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_slot  <= w_slot_nxt;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Outputs are loaded for the slot being entered, on the same edge as the step.
    always_comb begin
        w_dec_in = BCD_BLANK;
        case (w_slot_nxt)
            2'd0:    w_dec_in = r_units;
            2'd1:    w_dec_in = (r_tens == 4'd0) ? BCD_BLANK : r_tens;
            default: w_dec_in = BCD_BLANK;
        endcase
    end

    seg7_decoder u_dec (
        .i_bcd (w_dec_in),
        .o_seg (w_dec_seg)
    );

    assign w_seg_sel = ((w_slot_nxt == 2'd2) && r_neg) ? SEG_MINUS : w_dec_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else if (w_wrap) begin
            r_seg <= w_seg_sel;
            r_an  <= an_for_slot(w_slot_nxt);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with SCAN_DIV=4: reset, conversions,
// busy timing, change-while-busy, reset mid-conversion and idle display.
module tb_result_display;

    logic       clk;
    logic       rst_n;
    logic       sign;
    logic [4:0] mag;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    result_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sign  (sign),
        .mag   (mag),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Samples busy after each of the next 16 edges; optionally changes the input
    // right after sample change_at. Also returns an/seg seen after the 4th edge.
    task automatic capture_busy(input int change_at, input logic s2, input logic [4:0] m2,
                                output logic [15:0] pat, output logic [3:0] an3,
                                output logic [6:0] seg3);
        pat  = '0;
        an3  = '0;
        seg3 = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat[i] = busy;
            if (i == 3) begin
                an3  = an;
                seg3 = seg;
            end
            if (i == change_at) begin
                sign = s2;
                mag  = m2;
            end
        end
    endtask

    // Waits (bounded) until the given anode is active, then checks its pattern.
    task automatic show(input string tag, input logic [3:0] an_want, input logic [6:0] seg_want);
        int n;
        n = 0;
        while (an !== an_want && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"}, 16'(an), 16'(an_want));
        check(tag, 16'(seg), 16'(seg_want));
    endtask

    task automatic wait_scan();
        repeat (17) @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat;
        logic [3:0]  an3;
        logic [6:0]  seg3;
        int hi, bad, n0;

        // 1. Reset and first refresh
        rst_n = 1'b0;
        sign  = 1'b0;
        mag   = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_an", 16'(an), 16'h000F);
        check("rst_busy", 16'(busy), 16'h0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_wrap_seg", 16'(seg), 16'h007F);
        check("pre_wrap_an", 16'(an), 16'h000F);
        @(negedge clk);
        check("first_an", 16'(an), 16'h000E);
        check("first_seg", 16'(seg), 16'h0040);
        check("first_busy", 16'(busy), 16'h0000);

        // 2. +7: single digit, tens and sign blank
        sign = 1'b0;
        mag  = 5'd7;
        capture_busy(-1, 1'b0, 5'd0, pat, an3, seg3);
        check("p7_busy", pat, 16'h003F);
        wait_scan();
        show("p7_s0", 4'b1110, 7'b1111000);
        show("p7_s1", 4'b1101, 7'b1111111);
        show("p7_s2", 4'b1011, 7'b1111111);
        show("p7_s3", 4'b0111, 7'b1111111);

        // 3. -31
        sign = 1'b1;
        mag  = 5'd31;
        capture_busy(-1, 1'b0, 5'd0, pat, an3, seg3);
        check("m31_busy", pat, 16'h003F);
        wait_scan();
        show("m31_s0", 4'b1110, 7'b1111001);
        show("m31_s1", 4'b1101, 7'b0110000);
        show("m31_s2", 4'b1011, 7'b0111111);
        show("m31_s3", 4'b0111, 7'b1111111);

        // 4. 12 then 25 two cycles later: one idle cycle between busy pulses
        sign = 1'b0;
        mag  = 5'd12;
        capture_busy(1, 1'b0, 5'd25, pat, an3, seg3);
        check("chg_busy", pat, 16'h1FBF);
        wait_scan();
        show("p25_s1", 4'b1101, 7'b0100100);
        show("p25_s0", 4'b1110, 7'b0010010);
        show("p25_s2", 4'b1011, 7'b1111111);

        // 5. Reset during SHIFT iteration 2, then rerun with 20 still applied
        mag = 5'd20;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 16'(busy), 16'h0000);
        check("abort_seg", 16'(seg), 16'h007F);
        check("abort_an", 16'(an), 16'h000F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture_busy(-1, 1'b0, 5'd0, pat, an3, seg3);
        check("rerun_busy", pat, 16'h003F);
        check("rerun_first_an", 16'(an3), 16'h000E);
        check("rerun_first_seg", 16'(seg3), 16'h0040);
        wait_scan();
        show("p20_s0", 4'b1110, 7'b1000000);
        show("p20_s1", 4'b1101, 7'b0100100);
        show("p20_s2", 4'b1011, 7'b1111111);

        // 6. Input held at 0 after reset: no conversion, "   0" shown steadily
        mag   = 5'd0;
        sign  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hi  = 0;
        bad = 0;
        n0  = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (busy) hi++;
            if (an == 4'b1110) begin
                n0++;
                if (seg != 7'b1000000) bad++;
            end else if (seg != 7'b1111111) begin
                bad++;
            end
        end
        check("idle_busy_cycles", 16'(hi), 16'd0);
        check("idle_bad_samples", 16'(bad), 16'd0);
        check("idle_slot0_cycles", 16'(n0), 16'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
